// File: rtl/camera_pkg.sv
// Shared camera-stream types and constants for the pixel pipeline stages.
package camera_pkg;

  localparam int unsigned CAM_WIDTH  = 320;
  localparam int unsigned CAM_HEIGHT = 240;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Bits needed to hold a linear index 0 .. w*h-1.
  function automatic int unsigned idx_width(input int unsigned w, input int unsigned h);
    int unsigned n;
    n = w * h;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rgb565_window_match.sv
// Per-channel inclusive RGB565 window test; a channel with min > max never matches.
module rgb565_window_match
  import camera_pkg::*;
(
  input  logic [15:0] pixel,
  input  logic [15:0] col_min,
  input  logic [15:0] col_max,
  output logic        match
);

  rgb565_t w_px;
  rgb565_t w_mn;
  rgb565_t w_mx;

  assign w_px = rgb565_t'(pixel);
  assign w_mn = rgb565_t'(col_min);
  assign w_mx = rgb565_t'(col_max);

  assign match = (w_px.r >= w_mn.r) && (w_px.r <= w_mx.r) &&
                 (w_px.g >= w_mn.g) && (w_px.g <= w_mx.g) &&
                 (w_px.b >= w_mn.b) && (w_px.b <= w_mx.b);

endmodule

// File: rtl/pixel_coordinate_tagger.sv
// Tags camera pixels with x/y/linear index and a colour-match enable, and
// flags frames whose line/pixel counts are malformed.
module pixel_coordinate_tagger
  import camera_pkg::*;
#(
  parameter int unsigned WIDTH  = CAM_WIDTH,
  parameter int unsigned HEIGHT = CAM_HEIGHT,
  parameter int unsigned X_W    = 9,
  parameter int unsigned Y_W    = 8,
  parameter int unsigned IDX_W  = idx_width(WIDTH, HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             href,
  input  logic             pxl_valid,
  input  logic [15:0]      pixel,
  input  logic [15:0]      col_min,
  input  logic [15:0]      col_max,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [IDX_W-1:0] index,
  output logic             en,
  output logic             pxl_out_valid,
  output logic             frame_done,
  output logic             frame_ok
);

  localparam logic [X_W:0] ColLim = (X_W + 1)'(WIDTH);
  localparam logic [X_W:0] ColSat = '1;
  localparam logic [Y_W:0] RowLim = (Y_W + 1)'(HEIGHT);
  localparam logic [Y_W:0] RowSat = '1;

  logic             r_vsync, r_href;
  logic [X_W:0]     r_col, w_col_nxt;
  logic [Y_W:0]     r_row, w_row_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_err, w_err_nxt;
  logic [X_W-1:0]   r_x, w_x_nxt;
  logic [Y_W-1:0]   r_y, w_y_nxt;
  logic [IDX_W-1:0] r_index, w_index_nxt;
  logic             r_en, w_en_nxt;
  logic             r_pov, w_pov_nxt;
  logic             r_fd, w_fd_nxt;
  logic             r_fok, w_fok_nxt;

  logic w_match;
  logic w_vs_rise;
  logic w_href_fall;
  logic w_accept;

  rgb565_window_match u_match (
    .pixel   (pixel),
    .col_min (col_min),
    .col_max (col_max),
    .match   (w_match)
  );

  assign w_vs_rise   = vsync & ~r_vsync;
  assign w_href_fall = ~href & r_href;
  // A strobe coinciding with the href falling edge still belongs to the line.
  assign w_accept    = pxl_valid & ~vsync & (href | r_href);

  always_comb begin
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_index_nxt = r_index;
    w_en_nxt    = 1'b0;
    w_pov_nxt   = 1'b0;
    w_fd_nxt    = 1'b0;
    w_fok_nxt   = r_fok;

    if (w_vs_rise) begin
      w_fd_nxt  = 1'b1;
      w_fok_nxt = ~r_err && (r_row == RowLim);
      w_col_nxt = '0;
      w_row_nxt = '0;
      w_idx_nxt = '0;
      w_err_nxt = 1'b0;
    end else begin
      if (w_accept) begin
        if ((r_col < ColLim) && (r_row < RowLim)) begin
          w_x_nxt     = r_col[X_W-1:0];
          w_y_nxt     = r_row[Y_W-1:0];
          w_index_nxt = r_idx;
          w_pov_nxt   = 1'b1;
          w_en_nxt    = w_match;
          w_idx_nxt   = r_idx + 1'b1;
        end else begin
          w_err_nxt = 1'b1;
        end
        if (r_col != ColSat) begin
          w_col_nxt = r_col + 1'b1;
        end
      end
      // Line length is judged after any same-cycle pixel has been counted.
      if (w_href_fall) begin
        if (w_col_nxt != ColLim) begin
          w_err_nxt = 1'b1;
        end
        w_col_nxt = '0;
        if (r_row != RowSat) begin
          w_row_nxt = r_row + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_index <= '0;
      r_en    <= 1'b0;
      r_pov   <= 1'b0;
      r_fd    <= 1'b0;
      r_fok   <= 1'b0;
    end else begin
      r_vsync <= vsync;
      r_href  <= href;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_idx   <= w_idx_nxt;
      r_err   <= w_err_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_index <= w_index_nxt;
      r_en    <= w_en_nxt;
      r_pov   <= w_pov_nxt;
      r_fd    <= w_fd_nxt;
      r_fok   <= w_fok_nxt;
    end
  end

  assign x             = r_x;
  assign y             = r_y;
  assign index         = r_index;
  assign en            = r_en;
  assign pxl_out_valid = r_pov;
  assign frame_done    = r_fd;
  assign frame_ok      = r_fok;

endmodule

// File: tb/tb_pixel_coordinate_tagger.sv
// Scoreboard bench for pixel_coordinate_tagger on a reduced 12x8 frame geometry.
module tb_pixel_coordinate_tagger;

  localparam int W  = 12;
  localparam int H  = 8;
  localparam int XW = 4;
  localparam int YW = 3;
  localparam int IW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic          pxl_valid = 1'b0;
  logic [15:0]   pixel = '0;
  logic [15:0]   col_min = '0;
  logic [15:0]   col_max = 16'hFFFF;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [IW-1:0] index;
  logic          en, pxl_out_valid, frame_done, frame_ok;

  pixel_coordinate_tagger #(
    .WIDTH  (W),
    .HEIGHT (H),
    .X_W    (XW),
    .Y_W    (YW),
    .IDX_W  (IW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vsync         (vsync),
    .href          (href),
    .pxl_valid     (pxl_valid),
    .pixel         (pixel),
    .col_min       (col_min),
    .col_max       (col_max),
    .x             (x),
    .y             (y),
    .index         (index),
    .en            (en),
    .pxl_out_valid (pxl_out_valid),
    .frame_done    (frame_done),
    .frame_ok      (frame_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int idx;
    int en;
  } exp_t;

  exp_t        pq[$];
  int          fq[$];
  logic [15:0] force_px[$];
  int          tests = 0;
  int          fails = 0;
  int          en_cnt = 0;
  int          last_x = -1, last_y = -1, last_idx = -1;

  // Reference state: lines seen this frame, pixels emitted, frame spoiled.
  int m_row = 0;
  int m_idx = 0;
  bit m_bad = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int match_ref(input logic [15:0] p, input logic [15:0] mn,
                                   input logic [15:0] mx);
    int pr, pg, pb;
    pr = int'(p[15:11]);
    pg = int'(p[10:5]);
    pb = int'(p[4:0]);
    if (pr < int'(mn[15:11]) || pr > int'(mx[15:11])) return 0;
    if (pg < int'(mn[10:5])  || pg > int'(mx[10:5]))  return 0;
    if (pb < int'(mn[4:0])   || pb > int'(mx[4:0]))   return 0;
    return 1;
  endfunction

  task automatic cyc(input logic vs, input logic hr, input logic pv, input logic [15:0] px);
    vsync     = vs;
    href      = hr;
    pxl_valid = pv;
    pixel     = px;
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int len, input bit fall_last, input bit gaps, input bit do_end);
    logic [15:0] px;
    for (int k = 0; k < len; k++) begin
      px = (force_px.size() != 0) ? force_px.pop_front() : 16'($urandom);
      if (gaps && $urandom_range(0, 2) == 0) cyc(1'b0, 1'b1, 1'b0, 16'h0);
      if (k < W && m_row < H) begin
        pq.push_back('{k, m_row, m_idx, match_ref(px, col_min, col_max)});
        m_idx++;
      end else begin
        m_bad = 1'b1;
      end
      if (k == len - 1 && fall_last && do_end) cyc(1'b0, 1'b0, 1'b1, px);
      else cyc(1'b0, 1'b1, 1'b1, px);
    end
    if (do_end) begin
      cyc(1'b0, 1'b0, 1'b0, 16'h0);
      if (len != W) m_bad = 1'b1;
      if (m_row < 15) m_row++;
    end
  endtask

  task automatic send_frame(input int nlines, input bit gaps);
    for (int r = 0; r < nlines; r++) send_line(W, 1'b0, gaps, 1'b1);
  endtask

  task automatic vsync_pulse(input bit pv_same);
    fq.push_back((!m_bad && m_row == H) ? 1 : 0);
    m_row = 0;
    m_idx = 0;
    m_bad = 1'b0;
    cyc(1'b1, 1'b0, pv_same, 16'h1234);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, int'(x), 0);
    check({tag, "_y"}, int'(y), 0);
    check({tag, "_index"}, int'(index), 0);
    check({tag, "_en"}, int'(en), 0);
    check({tag, "_pxl_out_valid"}, int'(pxl_out_valid), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_frame_ok"}, int'(frame_ok), 0);
  endtask

  // Monitor: every output pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (pxl_out_valid) begin
        if (pq.size() == 0) begin
          check("unexpected_pixel", int'(pxl_out_valid), 0);
        end else begin
          e = pq.pop_front();
          check("pix_x", int'(x), e.x);
          check("pix_y", int'(y), e.y);
          check("pix_index", int'(index), e.idx);
          check("pix_en", int'(en), e.en);
          last_x   = int'(x);
          last_y   = int'(y);
          last_idx = int'(index);
        end
      end else if (en) begin
        check("en_without_valid", int'(en), int'(pxl_out_valid));
      end
      if (en) en_cnt++;
      if (frame_done) begin
        if (fq.size() == 0) check("unexpected_frame_done", int'(frame_done), 0);
        else check("frame_ok", int'(frame_ok), fq.pop_front());
      end
    end
  end

  initial begin
    int en0;
    #1 rst_n = 1'b0;
    #11;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    vsync_pulse(1'b0);

    // Full-range window: every in-area pixel must match.
    col_min = 16'h0000;
    col_max = 16'hFFFF;
    en0 = en_cnt;
    send_frame(H, 1'b1);
    check("full_frame_en_count", en_cnt - en0, W * H);
    check("last_x", last_x, W - 1);
    check("last_y", last_y, H - 1);
    check("last_index", last_idx, W * H - 1);
    vsync_pulse(1'b0);

    // Directed window R 20..31, G 0..10, B 0..10 including bound pixels.
    col_min = 16'hA000;
    col_max = 16'hF94A;
    force_px.push_back(16'hF800);
    force_px.push_back(16'h07E0);
    force_px.push_back(16'hA000);
    force_px.push_back(16'h9800);
    force_px.push_back(16'hF94A);
    force_px.push_back(16'hF96A);
    send_frame(H, 1'b0);
    vsync_pulse(1'b0);

    // Overlong line, then a line long enough to saturate the column counter.
    col_min = 16'($urandom);
    col_max = 16'($urandom);
    for (int r = 0; r < H; r++) begin
      send_line((r == 3) ? W + 1 : (r == 4) ? 40 : W, 1'b0, 1'b0, 1'b1);
    end
    vsync_pulse(1'b0);

    // Clean frame with same-cycle line ends and a stray strobe outside href.
    col_min = 16'($urandom);
    col_max = 16'($urandom);
    for (int r = 0; r < H; r++) begin
      send_line(W, (r == 2) || (r == H - 1), 1'b1, 1'b1);
      if (r == 1) cyc(1'b0, 1'b0, 1'b1, 16'($urandom));
    end
    vsync_pulse(1'b0);

    // Short frame; its closing vsync carries a pixel strobe that must be dropped.
    col_min = 16'h0000;
    col_max = 16'hFFFF;
    send_frame(H - 1, 1'b0);
    vsync_pulse(1'b1);
    send_frame(H + 1, 1'b0);
    vsync_pulse(1'b0);
    send_frame(H, 1'b1);
    vsync_pulse(1'b0);

    // Reset in the middle of line 5 after a good frame.
    send_frame(5, 1'b0);
    send_line(8, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0);
    check("pre_reset_x", int'(x), 7);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    pq.delete();
    fq.delete();
    m_row = 0;
    m_idx = 0;
    m_bad = 1'b0;
    href = 1'b0;
    pxl_valid = 1'b0;
    #20;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    vsync_pulse(1'b0);
    send_frame(H, 1'b0);
    vsync_pulse(1'b0);

    repeat (4) cyc(1'b0, 1'b0, 1'b0, 16'h0);
    check("pixel_queue_drained", pq.size(), 0);
    check("frame_queue_drained", fq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_coordinate_tagger.md
Name: pixel_coordinate_tagger

Overview:
- Upstream stage of the corner-centroid averager: converts the camera pixel stream (VSYNC/HREF/pixel strobe plus RGB565 data) into per-pixel coordinates, a linear pixel index and a colour-match enable.
- Output feeds the averager's x, y, index and en inputs directly.
- Also flags malformed frames so downstream logic can discard them.

Parameters:
- WIDTH, 320, active pixels per line.
- HEIGHT, 240, active lines per frame.
- X_W, 9, x coordinate width.
- Y_W, 8, y coordinate width.
- IDX_W, 17, pixel index width (must hold WIDTH*HEIGHT-1).

Ports:
- clk  in  1  system clock; all camera inputs are already synchronous to it.
- rst_n  in  1  asynchronous, active-low reset.
- vsync  in  1  camera frame sync, high during vertical blanking.
- href  in  1  camera line-valid, high during active pixels of a line.
- pxl_valid  in  1  one-cycle strobe, one per fully assembled pixel.
- pixel  in  16  RGB565 pixel: R[15:11], G[10:5], B[4:0].
- col_min  in  16  inclusive lower bound per channel, same RGB565 packing.
- col_max  in  16  inclusive upper bound per channel.
- x  out  X_W  column of the current output pixel.
- y  out  Y_W  row of the current output pixel.
- index  out  IDX_W  y*WIDTH + x of the current output pixel.
- en  out  1  one-cycle pulse: pixel in active area and colour-matched.
- pxl_out_valid  out  1  one-cycle pulse per in-area pixel, regardless of match.
- frame_done  out  1  one-cycle pulse on vsync rising edge.
- frame_ok  out  1  registered at frame_done: previous frame had exactly WIDTH pixels on each of HEIGHT lines.

Behaviour:
- Reset (rst_n low, asynchronous): all counters 0; x=0, y=0, index=0; en=0, pxl_out_valid=0, frame_done=0, frame_ok=0; vsync/href history registers cleared to 0.
- Edge detection: vsync and href are registered once per clk; rise and fall are derived by comparing the current input with its registered copy.
- Internal counters: col_cnt (X_W+1 bits), row_cnt (Y_W+1 bits), idx_cnt (IDX_W bits), plus a sticky error bit err.
- vsync rising edge:
  - pulse frame_done for one cycle.
  - frame_ok <= !err && (row_cnt==HEIGHT).
  - clear col_cnt, row_cnt, idx_cnt and err.
- href falling edge:
  - if col_cnt != WIDTH, set err.
  - row_cnt++ (saturates at 2^(Y_W+1)-1).
  - col_cnt <= 0.
- pxl_valid while href=1 and vsync=0:
  - if col_cnt<WIDTH and row_cnt<HEIGHT: register x<=col_cnt, y<=row_cnt, index<=idx_cnt; pulse pxl_out_valid; en<=match; then col_cnt++ and idx_cnt++.
  - otherwise (overrun): set err; col_cnt still increments (saturating); no output pulse; x/y/index hold.
- pxl_valid with href=0 or vsync=1: ignored entirely.
- Latency: outputs are registered 1 clk after the pxl_valid cycle. x, y and index hold between strobes.
- Colour match (combinational): R, G and B must each satisfy min<=ch<=max, compared unsigned per channel. If min>max for any channel, that channel never matches.
- Simultaneous events:
  - vsync rise has priority over href fall and pxl_valid in the same cycle.
  - href fall in the same cycle as pxl_valid: the pixel is counted first (using pre-increment row), then the line ends.
- en and pxl_out_valid are never high on consecutive cycles unless pxl_valid was.

Decomposition:
- Shared package camera_pkg:
  - rgb565_t packed struct {r[4:0], g[5:0], b[4:0]}.
  - Constants CAM_WIDTH=320, CAM_HEIGHT=240.
  - Localparam function for index width.
- One natural sub-module: rgb565_window_match (pixel, col_min, col_max -> match), reusable by other colour-classification stages.

Test Plan:
- Reset mid-line: assert rst_n=0 after 100 pixels of line 5 -> all outputs 0 immediately, without waiting for a clk edge; the next frame starts at x=0, y=0, index=0.
- Full 320x240 frame, col_min=0x0000, col_max=0xFFFF:
  - 76800 en pulses.
  - Last pixel outputs x=319, y=239, index=76799.
  - frame_done pulses at vsync rise with frame_ok=1.
- Window R 20..31, G 0..10, B 0..10: pixel 0xF800 -> en=1; 0x07E0 -> en=0, pxl_out_valid=1; 0xA000 (R=20, lower bound) -> en=1.
- Line of 321 pixels on row 7 -> the 321st produces no pulse; frame_ok=0 at the next vsync; the following clean frame gives frame_ok=1.
- Frame with 239 lines -> frame_ok=0. A pxl_valid with href=0 -> no output, counters unchanged.
- Same-cycle href fall + pxl_valid at col 319 -> pixel output x=319 on the current row; the next line starts at x=0, y+1. vsync rise and pxl_valid in the same cycle -> pixel dropped, counters cleared.
